sn_pack_adapter: RTL and testbench

- Parametrised successor to the plain snooper-to-P3 adapter.
- Packs RATIO consecutive narrow snooper words (SN_DATA_WIDTH) into one wide P3 write (RATIO*SN_DATA_WIDTH) and accumulates byte counts.
- Flushes a partially filled word before forwarding done. Runs the done/done_ack handshake through a small FSM.
- Sits between the snooper and the P3 ping/pang buffer write port; the rdy path passes through.

---
 rtl/sn_pack_pkg.sv | 29 ++
 rtl/sn_pack_lane_buf.sv | 92 +++++++++
 rtl/sn_pack_adapter.sv | 237 +++++++++++++++++++++++
 tb/tb_sn_pack_adapter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_pack_pkg.sv
// sn_pack_pkg -- shared types and width helpers for the snooper-to-P3 packing
// adapter.
//   state_t        : handshake/flush FSM states (S_RUN, S_FLUSH, S_DONE)
//   lane_bits      : address bits that select a narrow lane inside a wide word
//   lane_idx_width : width of a lane-index signal (never narrower than 1 bit)
//   data_width     : width of the packed P3 word
package sn_pack_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int lane_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 0;
  endfunction

  // With RATIO=1 there are no lane bits, but a lane index still needs a
  // legal 1-bit carrier that is tied to zero.
  function automatic int lane_idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int data_width(input int sn_dw, input int ratio);
    return sn_dw * ratio;
  endfunction

endpackage

// File: rtl/sn_pack_lane_buf.sv
// sn_pack_lane_buf -- holding register for one partially assembled wide word.
// Keeps the lane data, a per-lane written mask, the wide-address tag and the
// running byte count, and exposes the "buffer with the incoming lane merged
// in" view so the owner can emit a word in the same cycle its last lane
// arrives.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_lane/wr_tag  lane index and wide address of the incoming narrow word
//   wr_word/wr_inc  incoming narrow data and its valid-byte count
//   merge_en        merge the incoming word into the held word
//   fresh_en        discard held contents and start over with the incoming word
//   clear_en        empty the buffer (ignored when fresh_en is set)
//   held_*          current buffer contents
//   merged_data/acc held contents with the incoming word merged in
module sn_pack_lane_buf
  import sn_pack_pkg::*;
#(
  parameter int SN_ADDR_WIDTH = 10,
  parameter int SN_DATA_WIDTH = 32,
  parameter int RATIO         = 2,
  localparam int LANE_BITS  = lane_bits(RATIO),
  localparam int LANE_W     = lane_idx_width(RATIO),
  localparam int TAG_WIDTH  = SN_ADDR_WIDTH - LANE_BITS,
  localparam int DATA_WIDTH = data_width(SN_DATA_WIDTH, RATIO)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANE_W-1:0]        wr_lane,
  input  logic [TAG_WIDTH-1:0]     wr_tag,
  input  logic [SN_DATA_WIDTH-1:0] wr_word,
  input  logic [7:0]               wr_inc,
  input  logic                     merge_en,
  input  logic                     fresh_en,
  input  logic                     clear_en,
  output logic [DATA_WIDTH-1:0]    held_data,
  output logic [RATIO-1:0]         held_mask,
  output logic [TAG_WIDTH-1:0]     held_tag,
  output logic [7:0]               held_acc,
  output logic [DATA_WIDTH-1:0]    merged_data,
  output logic [7:0]               merged_acc
);

  logic [DATA_WIDTH-1:0] data_reg;
  logic [RATIO-1:0]      mask_reg;
  logic [TAG_WIDTH-1:0]  tag_reg;
  logic [7:0]            acc_reg;

  logic [RATIO-1:0]      lane_hit;
  logic [DATA_WIDTH-1:0] fresh_data;

  // Per-lane steering avoids a variable part-select on the wide register.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lane_hit[gi] = (wr_lane == LANE_W'(gi));
    assign merged_data[gi*SN_DATA_WIDTH +: SN_DATA_WIDTH] =
      lane_hit[gi] ? wr_word : data_reg[gi*SN_DATA_WIDTH +: SN_DATA_WIDTH];
    // A fresh word starts from all-zero lanes so unwritten lanes read as 0.
    assign fresh_data[gi*SN_DATA_WIDTH +: SN_DATA_WIDTH] =
      lane_hit[gi] ? wr_word : '0;
  end

  // Rewrites of a lane add their bytes again; the count wraps at 8 bits.
  assign merged_acc = acc_reg + wr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      mask_reg <= '0;
      tag_reg  <= '0;
      acc_reg  <= '0;
    end else if (fresh_en) begin
      data_reg <= fresh_data;
      mask_reg <= lane_hit;
      tag_reg  <= wr_tag;
      acc_reg  <= wr_inc;
    end else if (clear_en) begin
      data_reg <= '0;
      mask_reg <= '0;
      acc_reg  <= '0;
    end else if (merge_en) begin
      data_reg <= merged_data;
      mask_reg <= mask_reg | lane_hit;
      tag_reg  <= wr_tag;
      acc_reg  <= merged_acc;
    end
  end

  assign held_data = data_reg;
  assign held_mask = mask_reg;
  assign held_tag  = tag_reg;
  assign held_acc  = acc_reg;

endmodule

// File: rtl/sn_pack_adapter.sv
// sn_pack_adapter -- packs RATIO consecutive narrow snooper writes into one
// wide P3 ping/pang buffer write, accumulating byte counts, flushing any
// partial word before forwarding packet-done, and running the
// done/done_ack handshake. The rdy path passes straight through.
// Optional build macro: SN_PACK_WR_BE_EN adds the wr_be byte-enable output.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   sn_addr/sn_wr_data/sn_wr_en/sn_byte_inc  narrow write from the snooper
//   sn_done/sn_done_vld        packet done from the snooper
//   sn_done_ack                done accepted (same cycle as done_ack)
//   rdy_for_sn/_vld, rdy_ack   rdy path pass-through
//   addr/wr_en/wr_data/byte_inc  wide P3 write (registered)
//   wr_be                      byte enables of written lanes (optional)
//   done/done_vld/done_ack     done handshake towards P3
//   proto_err                  sticky: snooper wrote outside S_RUN
//   rdy/rdy_vld                P3 ready
module sn_pack_adapter
  import sn_pack_pkg::*;
#(
  parameter int SN_ADDR_WIDTH = 10,
  parameter int SN_DATA_WIDTH = 32,
  parameter int RATIO         = 2,
  localparam int LANE_BITS     = lane_bits(RATIO),
  localparam int LANE_W        = lane_idx_width(RATIO),
  localparam int TAG_WIDTH     = SN_ADDR_WIDTH - LANE_BITS,
  localparam int DATA_WIDTH    = data_width(SN_DATA_WIDTH, RATIO),
  localparam int P3_ADDR_WIDTH = SN_ADDR_WIDTH - LANE_BITS + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SN_ADDR_WIDTH-1:0] sn_addr,
  input  logic [SN_DATA_WIDTH-1:0] sn_wr_data,
  input  logic                     sn_wr_en,
  input  logic [7:0]               sn_byte_inc,
  input  logic                     sn_done,
  input  logic                     sn_done_vld,
  input  logic                     rdy_for_sn_ack,
  output logic                     sn_done_ack,
  output logic                     rdy_for_sn,
  output logic                     rdy_for_sn_vld,
  output logic [P3_ADDR_WIDTH-1:0] addr,
  output logic                     wr_en,
  output logic [DATA_WIDTH-1:0]    wr_data,
`ifdef SN_PACK_WR_BE_EN
  output logic [DATA_WIDTH/8-1:0]  wr_be,
`endif
  output logic [7:0]               byte_inc,
  output logic                     done,
  output logic                     done_vld,
  output logic                     rdy_ack,
  output logic                     proto_err,
  input  logic                     done_ack,
  input  logic                     rdy,
  input  logic                     rdy_vld
);

  state_t state_reg, state_next;

  logic [LANE_W-1:0]    lane;
  logic [TAG_WIDTH-1:0] tag;

  logic [DATA_WIDTH-1:0] held_data, merged_data;
  logic [RATIO-1:0]      held_mask;
  logic [TAG_WIDTH-1:0]  held_tag;
  logic [7:0]            held_acc, merged_acc;

  logic merge_en, fresh_en, clear_en;
  logic emit, emit_merged, latch_done;
  logic pending, tag_miss, last_lane;

  logic [DATA_WIDTH-1:0]    wr_data_reg;
  logic [P3_ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]               byte_inc_reg;
  logic                     wr_en_reg, done_reg, done_vld_reg, proto_err_reg;

  if (RATIO == 1) begin : g_single
    assign lane = '0;
    assign tag  = sn_addr;
  end else begin : g_multi
    assign lane = sn_addr[LANE_BITS-1:0];
    assign tag  = sn_addr[SN_ADDR_WIDTH-1:LANE_BITS];
  end

  sn_pack_lane_buf #(
    .SN_ADDR_WIDTH(SN_ADDR_WIDTH),
    .SN_DATA_WIDTH(SN_DATA_WIDTH),
    .RATIO        (RATIO)
  ) u_lane_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_lane    (lane),
    .wr_tag     (tag),
    .wr_word    (sn_wr_data),
    .wr_inc     (sn_byte_inc),
    .merge_en   (merge_en),
    .fresh_en   (fresh_en),
    .clear_en   (clear_en),
    .held_data  (held_data),
    .held_mask  (held_mask),
    .held_tag   (held_tag),
    .held_acc   (held_acc),
    .merged_data(merged_data),
    .merged_acc (merged_acc)
  );

  // The top lane of a held word is only ever set by a fresh load after an
  // eviction (a merged last-lane write emits immediately), so it marks a
  // complete word still waiting for its own emit slot.
  assign pending   = held_mask[RATIO-1];
  assign tag_miss  = (|held_mask) && (tag != held_tag);
  assign last_lane = (lane == LANE_W'(RATIO-1));

  always_comb begin
    state_next  = state_reg;
    merge_en    = 1'b0;
    fresh_en    = 1'b0;
    clear_en    = 1'b0;
    emit        = 1'b0;
    emit_merged = 1'b0;
    latch_done  = 1'b0;
    unique case (state_reg)
      S_RUN: begin
        if (sn_wr_en) begin
          if (pending || tag_miss) begin
            // Held word goes out; incoming word starts a new buffer.
            emit     = 1'b1;
            fresh_en = 1'b1;
          end else if (last_lane) begin
            emit        = 1'b1;
            emit_merged = 1'b1;
            clear_en    = 1'b1;
          end else begin
            merge_en = 1'b1;
          end
        end else if (pending) begin
          emit     = 1'b1;
          clear_en = 1'b1;
        end
        if (sn_done_vld) begin
          latch_done = 1'b1;
          // Decide on the buffer as it will be after this cycle's write.
          if (fresh_en || merge_en || (!clear_en && (|held_mask))) begin
            state_next = S_FLUSH;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_FLUSH: begin
        emit       = 1'b1;
        clear_en   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (done_ack) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  logic [DATA_WIDTH-1:0] emit_data;
  logic [TAG_WIDTH-1:0]  emit_tag;
  logic [7:0]            emit_acc;

  // A merged emit only happens without a tag miss, so the incoming tag is
  // the word's tag even when the buffer was empty.
  assign emit_data = emit_merged ? merged_data : held_data;
  assign emit_tag  = emit_merged ? tag : held_tag;
  assign emit_acc  = emit_merged ? merged_acc : held_acc;

`ifdef SN_PACK_WR_BE_EN
  localparam int LANE_BYTES = SN_DATA_WIDTH / 8;
  logic [RATIO-1:0]        lane_onehot;
  logic [RATIO-1:0]        emit_mask;
  logic [DATA_WIDTH/8-1:0] be_next;
  logic [DATA_WIDTH/8-1:0] wr_be_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_be
    assign lane_onehot[gi] = (lane == LANE_W'(gi));
    assign be_next[gi*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{emit_mask[gi]}};
  end
  assign emit_mask = emit_merged ? (held_mask | lane_onehot) : held_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_be_reg <= '0;
    end else if (emit) begin
      wr_be_reg <= be_next;
    end
  end
  assign wr_be = wr_be_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_RUN;
      wr_en_reg     <= 1'b0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      byte_inc_reg  <= '0;
      done_reg      <= 1'b0;
      done_vld_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= emit;
      if (emit) begin
        addr_reg     <= {emit_tag, 1'b0};
        wr_data_reg  <= emit_data;
        byte_inc_reg <= emit_acc;
      end
      if (latch_done) begin
        done_reg <= sn_done;
      end
      done_vld_reg <= (state_next == S_DONE);
      if (sn_wr_en && (state_reg != S_RUN)) begin
        proto_err_reg <= 1'b1;
      end
    end
  end

  assign wr_en     = wr_en_reg;
  assign addr      = addr_reg;
  assign wr_data   = wr_data_reg;
  assign byte_inc  = byte_inc_reg;
  assign done      = done_reg;
  assign done_vld  = done_vld_reg;
  assign proto_err = proto_err_reg;

  assign sn_done_ack    = done_ack && (state_reg == S_DONE);
  assign rdy_for_sn     = rdy;
  assign rdy_for_sn_vld = rdy_vld;
  assign rdy_ack        = rdy_for_sn_ack;

endmodule

// File: tb/tb_sn_pack_adapter.sv
// Bench for sn_pack_adapter: a word-level model (lane array + written flags)
// predicts every registered output and the combinational pass-throughs, and
// a negedge compare process checks the RATIO=2 instance every cycle. Literal
// expectations pin the model, and a RATIO=4/16-bit instance covers the
// partial-word flush with byte enables.
module tb_sn_pack_adapter;

  localparam int R  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- RATIO=2 instance ----------------
  logic [9:0]  i_addr = '0;
  logic [31:0] i_data = '0;
  logic        i_wr = 1'b0, i_d = 1'b0, i_dv = 1'b0, i_sack = 1'b0;
  logic [7:0]  i_inc = '0;
  logic        i_ack = 1'b0, i_rdy = 1'b0, i_rvld = 1'b0;

  logic        o_sn_done_ack, o_rdy_for_sn, o_rdy_for_sn_vld, o_wr_en;
  logic [9:0]  o_addr;
  logic [63:0] o_wr_data;
  logic [7:0]  o_byte_inc;
  logic        o_done, o_done_vld, o_rdy_ack, o_proto_err;
`ifdef SN_PACK_WR_BE_EN
  logic [7:0]  o_wr_be;
`endif

  sn_pack_adapter #(.SN_ADDR_WIDTH(10), .SN_DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst(rst),
    .sn_addr(i_addr), .sn_wr_data(i_data), .sn_wr_en(i_wr),
    .sn_byte_inc(i_inc), .sn_done(i_d), .sn_done_vld(i_dv),
    .rdy_for_sn_ack(i_sack), .sn_done_ack(o_sn_done_ack),
    .rdy_for_sn(o_rdy_for_sn), .rdy_for_sn_vld(o_rdy_for_sn_vld),
    .addr(o_addr), .wr_en(o_wr_en), .wr_data(o_wr_data),
`ifdef SN_PACK_WR_BE_EN
    .wr_be(o_wr_be),
`endif
    .byte_inc(o_byte_inc), .done(o_done), .done_vld(o_done_vld),
    .rdy_ack(o_rdy_ack), .proto_err(o_proto_err),
    .done_ack(i_ack), .rdy(i_rdy), .rdy_vld(i_rvld)
  );

  // ---------------- RATIO=4, 16-bit instance ----------------
  logic [9:0]  q_addr = '0;
  logic [15:0] q_data = '0;
  logic        q_wr = 1'b0, q_d = 1'b0, q_dv = 1'b0, q_ack = 1'b0;
  logic [7:0]  q_inc = '0;
  logic        q_sn_done_ack, q_rfs, q_rfsv, q_wr_en, q_done, q_done_vld;
  logic        q_rdy_ack, q_proto_err;
  logic [8:0]  q_addr_o;
  logic [63:0] q_wr_data;
  logic [7:0]  q_byte_inc;
`ifdef SN_PACK_WR_BE_EN
  logic [7:0]  q_wr_be;
`endif

  sn_pack_adapter #(.SN_ADDR_WIDTH(10), .SN_DATA_WIDTH(16), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst),
    .sn_addr(q_addr), .sn_wr_data(q_data), .sn_wr_en(q_wr),
    .sn_byte_inc(q_inc), .sn_done(q_d), .sn_done_vld(q_dv),
    .rdy_for_sn_ack(1'b0), .sn_done_ack(q_sn_done_ack),
    .rdy_for_sn(q_rfs), .rdy_for_sn_vld(q_rfsv),
    .addr(q_addr_o), .wr_en(q_wr_en), .wr_data(q_wr_data),
`ifdef SN_PACK_WR_BE_EN
    .wr_be(q_wr_be),
`endif
    .byte_inc(q_byte_inc), .done(q_done), .done_vld(q_done_vld),
    .rdy_ack(q_rdy_ack), .proto_err(q_proto_err),
    .done_ack(q_ack), .rdy(1'b0), .rdy_vld(1'b0)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  // phase: 0 = accepting writes, 1 = flushing, 2 = waiting for done_ack
  logic [31:0] m_lane [R];
  bit          m_have [R];
  int          m_tag, m_acc, m_phase;
  bit          m_done, m_err;
  logic [31:0] n_lane [R];
  bit          n_have [R];
  int          n_tag, n_acc, n_phase;
  bit          n_done, n_err;
  // expected registered outputs: e_* now, ne_* after the next edge
  bit          e_wr_en, ne_wr_en;
  logic [9:0]  e_addr, ne_addr;
  logic [63:0] e_data, ne_data;
  logic [7:0]  e_inc, ne_inc, e_be, ne_be;
  bit          exp_sack;

  task automatic model_reset();
    for (int k = 0; k < R; k++) begin
      m_lane[k] = '0; m_have[k] = 0; n_lane[k] = '0; n_have[k] = 0;
    end
    m_tag = 0; m_acc = 0; m_phase = 0; m_done = 0; m_err = 0;
    n_tag = 0; n_acc = 0; n_phase = 0; n_done = 0; n_err = 0;
    e_wr_en = 0; e_addr = '0; e_data = '0; e_inc = '0; e_be = '0;
    ne_wr_en = 0; ne_addr = '0; ne_data = '0; ne_inc = '0; ne_be = '0;
    exp_sack = 0;
  endtask

  // Send the word being assembled to P3 and start an empty one.
  task automatic model_emit();
    ne_wr_en = 1;
    ne_addr  = 10'(n_tag * 2);
    ne_data  = '0;
    ne_be    = '0;
    for (int k = 0; k < R; k++) begin
      if (n_have[k]) begin
        ne_data[k*DW +: DW] = n_lane[k];
        ne_be[k*4 +: 4]     = 4'hF;
      end
      n_have[k] = 0;
    end
    ne_inc = 8'(n_acc);
    n_acc  = 0;
  endtask

  task automatic model_eval();
    bit any, any_after, evicted;
    int lane, tg;
    for (int k = 0; k < R; k++) begin
      n_lane[k] = m_lane[k]; n_have[k] = m_have[k];
    end
    n_tag = m_tag; n_acc = m_acc; n_phase = m_phase; n_done = m_done; n_err = m_err;
    ne_wr_en = 0; ne_addr = e_addr; ne_data = e_data; ne_inc = e_inc; ne_be = e_be;
    exp_sack = i_ack && (m_phase == 2);
    any = 0;
    for (int k = 0; k < R; k++) any |= m_have[k];
    if (m_phase == 0) begin
      if (i_wr) begin
        lane = int'(i_addr) % R;
        tg   = int'(i_addr) / R;
        evicted = any && ((tg != n_tag) || n_have[R-1]);
        if (evicted) model_emit();
        n_lane[lane] = i_data;
        n_have[lane] = 1;
        n_tag = tg;
        n_acc = (n_acc + int'(i_inc)) % 256;
        if (!evicted && lane == R-1) model_emit();
      end else if (n_have[R-1]) begin
        model_emit();
      end
      if (i_dv) begin
        n_done = i_d;
        any_after = 0;
        for (int k = 0; k < R; k++) any_after |= n_have[k];
        n_phase = any_after ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      model_emit();
      n_phase = 2;
    end else begin
      if (i_ack) n_phase = 0;
    end
    if (i_wr && m_phase != 0) n_err = 1;
  endtask

  task automatic model_commit();
    for (int k = 0; k < R; k++) begin
      m_lane[k] = n_lane[k]; m_have[k] = n_have[k];
    end
    m_tag = n_tag; m_acc = n_acc; m_phase = n_phase; m_done = n_done; m_err = n_err;
    e_wr_en = ne_wr_en; e_addr = ne_addr; e_data = ne_data; e_inc = ne_inc; e_be = ne_be;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en && !rst) begin
      cmp("wr_en", 64'(o_wr_en), 64'(e_wr_en));
      if (e_wr_en) begin
        cmp("addr", 64'(o_addr), 64'(e_addr));
        cmp("wr_data", o_wr_data, e_data);
        cmp("byte_inc", 64'(o_byte_inc), 64'(e_inc));
`ifdef SN_PACK_WR_BE_EN
        cmp("wr_be", 64'(o_wr_be), 64'(e_be));
`endif
      end
      cmp("done", 64'(o_done), 64'(m_done));
      cmp("done_vld", 64'(o_done_vld), 64'(m_phase == 2));
      cmp("proto_err", 64'(o_proto_err), 64'(m_err));
      cmp("sn_done_ack", 64'(o_sn_done_ack), 64'(exp_sack));
      cmp("rdy_for_sn", 64'(o_rdy_for_sn), 64'(i_rdy));
      cmp("rdy_for_sn_vld", 64'(o_rdy_for_sn_vld), 64'(i_rvld));
      cmp("rdy_ack", 64'(o_rdy_ack), 64'(i_sack));
    end
  end

  // One snooper/P3 cycle on the RATIO=2 instance.
  task automatic step(input bit wr, input int a, input logic [31:0] d, input int inc,
                      input bit dv, input bit dn, input bit ack);
    @(posedge clk);
    #1;
    model_commit();
    cyc++;
    i_wr = wr; i_addr = 10'(a); i_data = d; i_inc = 8'(inc);
    i_dv = dv; i_d = dn; i_ack = ack;
    i_rdy = cyc[0]; i_rvld = cyc[1]; i_sack = cyc[2];
    model_eval();
    $display("cycle %0d: wr=%0d addr=%0d data=%h inc=%0d dv=%0d done=%0d ack=%0d",
             cyc, wr, a, d, inc, dv, dn, ack);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input int inc);
    step(1, a, d, inc, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_eval();
    check_en = 1'b1;

    idle();
    @(negedge clk);
    cmp("reset wr_en", 64'(o_wr_en), 64'd0);
    cmp("reset done_vld", 64'(o_done_vld), 64'd0);

    // Two lanes of wide word 2 make one write.
    wr(4, 32'h11111111, 4);
    wr(5, 32'h22222222, 4);
    idle();
    @(negedge clk);
    cmp("lit full wr_en", 64'(o_wr_en), 64'd1);
    cmp("lit full addr", 64'(o_addr), 64'h4);
    cmp("lit full data", o_wr_data, 64'h22222222_11111111);
    cmp("lit full inc", 64'(o_byte_inc), 64'd8);

    // Partial word flushed before done.
    wr(6, 32'h33333333, 3);
    step(0, 0, 32'h0, 0, 1, 1, 0);
    idle();
    idle();
    @(negedge clk);
    cmp("lit flush wr_en", 64'(o_wr_en), 64'd1);
    cmp("lit flush data", o_wr_data, 64'h00000000_33333333);
    cmp("lit flush inc", 64'(o_byte_inc), 64'd3);
    cmp("lit flush done_vld", 64'(o_done_vld), 64'd1);
    cmp("lit flush done", 64'(o_done), 64'd1);
    step(0, 0, 32'h0, 0, 0, 0, 1);
    @(negedge clk);
    cmp("lit sn_done_ack", 64'(o_sn_done_ack), 64'd1);
    idle();

    // Address change evicts the held partial word.
    wr(8, 32'hAAAA0000, 2);
    wr(10, 32'hBBBB0000, 1);
    idle();
    @(negedge clk);
    cmp("lit evict addr", 64'(o_addr), 64'h8);
    cmp("lit evict data", o_wr_data, 64'h00000000_AAAA0000);
    cmp("lit evict inc", 64'(o_byte_inc), 64'd2);
    wr(11, 32'hCCCC0000, 4);
    idle();
    @(negedge clk);
    cmp("lit held lane data", o_wr_data, 64'hCCCC0000_BBBB0000);
    cmp("lit held lane inc", 64'(o_byte_inc), 64'd5);

    // Eviction whose new word already has its last lane.
    wr(14, 32'h0E0E0E0E, 1);
    wr(17, 32'h17171717, 2);
    idle();
    idle();
    @(negedge clk);
    cmp("lit pending addr", 64'(o_addr), 64'd16);
    cmp("lit pending data", o_wr_data, 64'h17171717_00000000);

    // Lane rewrite overwrites data and adds bytes again.
    wr(20, 32'h00000001, 2);
    wr(20, 32'h00000002, 3);
    wr(21, 32'h00000003, 1);
    idle();
    @(negedge clk);
    cmp("lit rewrite data", o_wr_data, 64'h00000003_00000002);
    cmp("lit rewrite inc", 64'(o_byte_inc), 64'd6);

    // Completing write together with done: no extra flush write.
    wr(8, 32'h88888888, 4);
    step(1, 9, 32'h99999999, 4, 1, 0, 0);
    idle();
    idle();
    @(negedge clk);
    cmp("lit no flush wr_en", 64'(o_wr_en), 64'd0);
    cmp("lit no flush done_vld", 64'(o_done_vld), 64'd1);

    // Write while waiting for done_ack is dropped and flagged.
    wr(12, 32'hDEADBEEF, 4);
    step(0, 0, 32'h0, 0, 0, 0, 1);
    idle();
    idle();
    @(negedge clk);
    cmp("lit proto_err sticky", 64'(o_proto_err), 64'd1);
    cmp("lit dropped wr_en", 64'(o_wr_en), 64'd0);

    // Back-to-back full words.
    for (int k = 0; k < 6; k++) wr(40 + k, 32'h10000000 + 32'(k), k + 1);

    // Reset in the middle of a word.
    wr(30, 32'h30303030, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_wr = 0; i_dv = 0; i_ack = 0;
    model_reset();
    #1;
    cmp("rst wr_en", 64'(o_wr_en), 64'd0);
    cmp("rst addr", 64'(o_addr), 64'd0);
    cmp("rst data", o_wr_data, 64'd0);
    cmp("rst inc", 64'(o_byte_inc), 64'd0);
    cmp("rst done_vld", 64'(o_done_vld), 64'd0);
    cmp("rst proto_err", 64'(o_proto_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_eval();
    wr(31, 32'h31313131, 2);
    idle();
    @(negedge clk);
    cmp("lit post-rst data", o_wr_data, 64'h31313131_00000000);
    cmp("lit post-rst inc", 64'(o_byte_inc), 64'd2);
    idle();

    // RATIO=4, 16-bit lanes: lanes 0 and 2, then done.
    @(posedge clk); #1;
    q_wr = 1; q_addr = 10'd0; q_data = 16'hAAAA; q_inc = 8'd2;
    @(posedge clk); #1;
    q_addr = 10'd2; q_data = 16'hCCCC;
    @(posedge clk); #1;
    q_wr = 0; q_dv = 1; q_d = 1;
    @(posedge clk); #1;
    q_dv = 0;
    @(posedge clk); #1;
    $display("ratio4 flush: wr_en=%0d data=%h inc=%0d", q_wr_en, q_wr_data, q_byte_inc);
    cmp("r4 wr_en", 64'(q_wr_en), 64'd1);
    cmp("r4 addr", 64'(q_addr_o), 64'd0);
    cmp("r4 data", q_wr_data, 64'h0000_CCCC_0000_AAAA);
    cmp("r4 inc", 64'(q_byte_inc), 64'd4);
`ifdef SN_PACK_WR_BE_EN
    cmp("r4 wr_be", 64'(q_wr_be), 64'b00110011);
`endif
    cmp("r4 done_vld", 64'(q_done_vld), 64'd1);
    q_ack = 1;
    #1;
    cmp("r4 sn_done_ack", 64'(q_sn_done_ack), 64'd1);
    @(posedge clk); #1;
    q_ack = 0;
    cmp("r4 done_vld drop", 64'(q_done_vld), 64'd0);

    idle();
    idle();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
